// File: rtl/spi_master.sv
// rtl/spi_master.sv - dual chip-select SPI master (mode 0, MSB first)
//
// Sends one command frame on spi_cs_cmd, then one full-duplex data frame on
// spi_cs_data. The controller side uses a start/done handshake.
//
// Optional feature macro: SPI_MASTER_CMD_PHASE_EN
//   defined   : command frame + gap precede the data frame
//   undefined : data frame only, spi_cs_cmd held high, cmd_in unused
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   start        transaction request, accepted only in IDLE
//   cmd_in       command word, latched at acceptance
//   txd_data     data word to send, latched at acceptance
//   rxd_data     word received from the slave, valid while done=1
//   busy         high from acceptance until the done cycle
//   done         one-cycle end-of-transaction pulse
//   spi_sck      SPI clock, idles low
//   spi_sdo      master-to-slave data
//   spi_sdi      slave-to-master data
//   spi_cs_cmd   command select, active-low
//   spi_cs_data  data select, active-low

module spi_master #(
  parameter int data_width = 16,
  parameter int cmd_width  = 8,
  parameter int half_div   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [cmd_width-1:0]  cmd_in,
  input  logic [data_width-1:0] txd_data,
  output logic [data_width-1:0] rxd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_sck,
  output logic                  spi_sdo,
  input  logic                  spi_sdi,
  output logic                  spi_cs_cmd,
  output logic                  spi_cs_data
);

  localparam int CW   = (half_div > 1) ? $clog2(half_div) : 1;
  localparam int MAXW = (data_width > cmd_width) ? data_width : cmd_width;
  localparam int BW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [CW-1:0] H_LAST    = CW'(half_div - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(data_width - 1);
`ifdef SPI_MASTER_CMD_PHASE_EN
  localparam logic [BW-1:0] CMD_LAST  = BW'(cmd_width - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_LEAD,
    S_CMD_SHIFT,
    S_CMD_TRAIL,
    S_GAP,
    S_DATA_LEAD,
    S_DATA_SHIFT,
    S_DATA_TRAIL,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [BW-1:0]         bit_q;
  logic                  hi_q;       // 1 while in the SCK-high half of a bit
  logic                  sck_q;
  logic                  sdo_q;
  logic                  cs_cmd_q;
  logic                  cs_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic [data_width-1:0] rxd_q;
  // The MSB goes straight onto spi_sdo at acceptance, so the shift
  // registers only hold the remaining bits.
  logic [data_width-2:0] data_sr_q;
  // Holds the first data_width-1 received bits; the final bit is taken
  // straight from spi_sdi when rxd_data is loaded.
  logic [data_width-2:0] rx_sr_q;
  logic                  phase_end;

`ifdef SPI_MASTER_CMD_PHASE_EN
  logic [cmd_width-2:0]  cmd_sr_q;
  logic                  data_msb_q;  // data MSB, driven when the data frame opens
`else
  logic                  unused_cmd;
  assign unused_cmd = ^cmd_in;
`endif

  // Every phase (lead, half-bit, trail, gap) lasts half_div cycles.
  assign phase_end = (cnt_q == H_LAST);
  assign cnt_d     = phase_end ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      hi_q       <= 1'b0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      cs_cmd_q   <= 1'b1;
      cs_data_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rxd_q      <= '0;
      data_sr_q  <= '0;
      rx_sr_q    <= '0;
`ifdef SPI_MASTER_CMD_PHASE_EN
      cmd_sr_q   <= '0;
      data_msb_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            busy_q    <= 1'b1;
            data_sr_q <= txd_data[data_width-2:0];
`ifdef SPI_MASTER_CMD_PHASE_EN
            cmd_sr_q   <= cmd_in[cmd_width-2:0];
            data_msb_q <= txd_data[data_width-1];
            sdo_q      <= cmd_in[cmd_width-1];
            cs_cmd_q   <= 1'b0;
            state_q    <= S_CMD_LEAD;
`else
            sdo_q     <= txd_data[data_width-1];
            cs_data_q <= 1'b0;
            state_q   <= S_DATA_LEAD;
`endif
          end
        end

`ifdef SPI_MASTER_CMD_PHASE_EN
        S_CMD_LEAD: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            hi_q    <= 1'b0;
            bit_q   <= '0;
            state_q <= S_CMD_SHIFT;
          end
        end

        S_CMD_SHIFT: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            if (!hi_q) begin
              hi_q  <= 1'b1;
              sck_q <= 1'b1;
            end else begin
              // Falling edge: next command bit goes out with it.
              hi_q     <= 1'b0;
              sck_q    <= 1'b0;
              sdo_q    <= cmd_sr_q[cmd_width-2];
              cmd_sr_q <= cmd_sr_q << 1;
              if (bit_q == CMD_LAST) begin
                state_q <= S_CMD_TRAIL;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end
          end
        end

        S_CMD_TRAIL: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            cs_cmd_q <= 1'b1;
            state_q  <= S_GAP;
          end
        end

        S_GAP: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            cs_data_q <= 1'b0;
            sdo_q     <= data_msb_q;
            state_q   <= S_DATA_LEAD;
          end
        end
`endif

        S_DATA_LEAD: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            hi_q    <= 1'b0;
            bit_q   <= '0;
            state_q <= S_DATA_SHIFT;
          end
        end

        S_DATA_SHIFT: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            if (!hi_q) begin
              hi_q  <= 1'b1;
              sck_q <= 1'b1;
            end else begin
              // The slave's bit k appears after falling edge k, so the
              // sample taken at the end of bit j's high phase is bit j-1.
              // Nothing valid is on spi_sdi before the first falling edge.
              if (bit_q != '0) begin
                rx_sr_q <= {rx_sr_q[data_width-3:0], spi_sdi};
              end
              hi_q      <= 1'b0;
              sck_q     <= 1'b0;
              sdo_q     <= data_sr_q[data_width-2];
              data_sr_q <= data_sr_q << 1;
              if (bit_q == DATA_LAST) begin
                state_q <= S_DATA_TRAIL;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end
          end
        end

        S_DATA_TRAIL: begin
          cnt_q <= cnt_d;
          if (phase_end) begin
            // Last slave bit arrived after the final falling edge.
            rxd_q     <= {rx_sr_q, spi_sdi};
            cs_data_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rxd_data    = rxd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign spi_sck     = sck_q;
  assign spi_sdo     = sdo_q;
  assign spi_cs_cmd  = cs_cmd_q;
  assign spi_cs_data = cs_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int H  = 4;

`ifdef SPI_MASTER_CMD_PHASE_EN
  localparam int LAT        = H * (2 * CW + 2 * DW + 5) + 1;
  localparam int CMD_LOW    = H * (2 * CW + 2);
  localparam int DATA_FIRST = H * (2 * CW + 3) + 1;
`else
  localparam int LAT        = H * (2 * DW + 2) + 1;
  localparam int CMD_LOW    = 0;
  localparam int DATA_FIRST = 1;
`endif
  localparam int DATA_LOW = H * (2 * DW + 2);

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] cmd_in;
  logic [DW-1:0] txd_data;
  logic [DW-1:0] rxd_data;
  logic          busy;
  logic          done;
  logic          spi_sck;
  logic          spi_sdo;
  logic          spi_sdi = 1'b0;
  logic          spi_cs_cmd;
  logic          spi_cs_data;

  int checks = 0;
  int errors = 0;

  spi_master #(
    .data_width(DW),
    .cmd_width (CW),
    .half_div  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd_in     (cmd_in),
    .txd_data   (txd_data),
    .rxd_data   (rxd_data),
    .busy       (busy),
    .done       (done),
    .spi_sck    (spi_sck),
    .spi_sdo    (spi_sdo),
    .spi_sdi    (spi_sdi),
    .spi_cs_cmd (spi_cs_cmd),
    .spi_cs_data(spi_cs_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mode-0 slave: captures on SCK rise, presents bit k after
  // SCK falling edge k.
  logic [DW-1:0] s_tx = '0;
  logic [DW-1:0] s_txsr = '0;
  logic [DW-1:0] s_rx = '0;
  logic [CW-1:0] s_cmd = '0;
  int            s_rbits = 0;
  int            s_cbits = 0;
  int            sdo_viol = 0;

  always @(negedge spi_cs_data) begin
    s_txsr  = s_tx;
    s_rbits = 0;
  end

  always @(negedge spi_cs_cmd) s_cbits = 0;

  always @(negedge spi_sck) begin
    if (!spi_cs_data) begin
      spi_sdi = s_txsr[DW-1];
      s_txsr  = s_txsr << 1;
    end
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_data) begin
      s_rx    = {s_rx[DW-2:0], spi_sdo};
      s_rbits = s_rbits + 1;
    end
    if (!spi_cs_cmd) begin
      s_cmd   = {s_cmd[CW-2:0], spi_sdo};
      s_cbits = s_cbits + 1;
    end
  end

  always @(spi_sdo) begin
    if (rst && spi_sck) sdo_viol = sdo_viol + 1;
  end

  typedef struct {
    logic [CW-1:0] cmd;
    logic [DW-1:0] data;
    logic [DW-1:0] rx;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rxd_data", {16'h0, rxd_data}, {16'h0, e.rx});
      chk("slave_data", {16'h0, s_rx}, {16'h0, e.data});
      chk("slave_data_bits", s_rbits, 32'd16);
`ifdef SPI_MASTER_CMD_PHASE_EN
      chk("slave_cmd", {24'h0, s_cmd}, {24'h0, e.cmd});
      chk("slave_cmd_bits", s_cbits, 32'd8);
`endif
    end
  endtask

  task automatic run_txn(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [DW-1:0] stx);
    int cyc;
    int cmd_low;
    int data_low;
    int data_first;
    exp_t e;
    e.cmd = c;
    e.data = d;
    e.rx = stx;
    s_tx = stx;
    sb.push_back(e);
    @(negedge clk);
    cmd_in   = c;
    txd_data = d;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", {31'h0, busy}, 32'd1);
    chk("cs_low_cycle1", {31'h0, spi_cs_cmd & spi_cs_data}, 32'd0);
    cyc        = 1;
    cmd_low    = 0;
    data_low   = 0;
    data_first = 0;
    while (!done && cyc < LAT + 50) begin
      if (!spi_cs_cmd) cmd_low++;
      if (!spi_cs_data) begin
        data_low++;
        if (data_first == 0) data_first = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", cyc, LAT);
    chk("cs_cmd_low_cycles", cmd_low, CMD_LOW);
    chk("cs_data_low_cycles", data_low, DATA_LOW);
    chk("cs_data_first_cycle", data_first, DATA_FIRST);
    chk("busy_at_done", {31'h0, busy}, 32'd0);
    pop_check();
    @(negedge clk);
    chk("done_one_cycle", {31'h0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int first_done;
    int second_done;
    int win_done;
    int seen_done;
    exp_t e;

    rst      = 1'b0;
    start    = 1'b0;
    cmd_in   = '0;
    txd_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("reset_sck", {31'h0, spi_sck}, 32'd0);
    chk("reset_sdo", {31'h0, spi_sdo}, 32'd0);
    chk("reset_cs_cmd", {31'h0, spi_cs_cmd}, 32'd1);
    chk("reset_cs_data", {31'h0, spi_cs_data}, 32'd1);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_rxd", {16'h0, rxd_data}, 32'd0);

    run_txn(8'hA5, 16'h1234, 16'h5A5A);
    run_txn(8'h00, 16'h0000, 16'hBEEF);
    run_txn(8'h3C, 16'h8001, 16'h0001);
    run_txn(8'hC3, 16'h7FFE, 16'h0001);

    // start held high: DONE-cycle start is ignored, next cycle accepts.
    s_tx   = 16'h1357;
    e.cmd  = 8'h66;
    e.data = 16'h9ABC;
    e.rx   = 16'h1357;
    repeat (3) sb.push_back(e);
    @(negedge clk);
    cmd_in   = 8'h66;
    txd_data = 16'h9ABC;
    start    = 1'b1;
    ndone       = 0;
    first_done  = 0;
    second_done = 0;
    win_done    = 0;
    for (int c = 1; c <= 3 * LAT + 20 && ndone < 3; c++) begin
      @(negedge clk);
      if (c == 2 * LAT + 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (c < 2 * LAT + 10) win_done++;
        if (ndone == 1) first_done = c;
        if (ndone == 2) second_done = c;
        pop_check();
      end
    end
    chk("held_start_done_in_window", win_done, 32'd2);
    chk("held_start_first_done", first_done, LAT);
    chk("held_start_second_done", second_done, 2 * LAT + 1);
    chk("held_start_total_done", ndone, 32'd3);
    @(negedge clk);

    // Asynchronous reset in cycle 100 of a transaction.
    s_tx = 16'hFFFF;
    @(negedge clk);
    cmd_in   = 8'h81;
    txd_data = 16'hF00F;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_cs_cmd", {31'h0, spi_cs_cmd}, 32'd1);
    chk("abort_cs_data", {31'h0, spi_cs_data}, 32'd1);
    chk("abort_sck", {31'h0, spi_sck}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_rxd", {16'h0, rxd_data}, 32'd0);
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst = 1'b1;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort_no_done", seen_done, 32'd0);

    run_txn(8'h5A, 16'h0F0F, 16'hA5A5);

    chk("sdo_stable_while_sck_high", sdo_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Master end of the team's dual-chip-select SPI link: drives one command frame on `spi_cs_cmd`, then one full-duplex data frame on `spi_cs_data`, toward the FPGA-side SPI slave (MSB first, mode 0). It sits between a local controller (start/done handshake) and the four-wire pins. It is used as a bench driver for the slave and as an on-board master when a second FPGA hosts the slave.

## Interface
- Parameters:
- `data_width`, 16: bits per data frame.
- `cmd_width`, 8: bits per command frame.
- `half_div`, 4: `clk` cycles per SCK half-period; must be ≥4 to cover the slave's 3-cycle synchroniser latency.
- Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-low reset.
- `start`  in  1  request a transaction; accepted only in IDLE.
- `cmd_in`  in  cmd_width  command to send; latched at acceptance.
- `txd_data`  in  data_width  data to send; latched at acceptance.
- `rxd_data`  out  data_width  word received from slave; valid when `done`=1.
- `busy`  out  1  high from acceptance until the `done` cycle.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `spi_sck`  out  1  SPI clock; idles low.
- `spi_sdo`  out  1  master-to-slave data.
- `spi_sdi`  in  1  slave-to-master data.
- `spi_cs_cmd`  out  1  command select, active-low.
- `spi_cs_data`  out  1  data select, active-low.

## Operation
- Reset values:
- `spi_sck`=0, `spi_sdo`=0, `spi_cs_cmd`=1, `spi_cs_data`=1.
- `busy`=0, `done`=0, `rxd_data`=0.
- State is IDLE.
- States: IDLE → CMD_LEAD → CMD_SHIFT → CMD_TRAIL → GAP → DATA_LEAD → DATA_SHIFT → DATA_TRAIL → DONE → IDLE.
- IDLE: when `start`=1, latch `cmd_in` and `txd_data` into shift registers and go to CMD_LEAD. `start` while busy is ignored; no queueing.
- LEAD (H = `half_div` cycles): CS low, SCK low, MSB driven on `spi_sdo`.
- SHIFT: N bits, each bit = H cycles SCK low, then H cycles SCK high.
- Each bit begins with SCK low for H cycles, then SCK high for H cycles.
- `spi_sdo` changes only on SCK falling edges (bit k+1 after falling edge k) and is stable around rising edges.
- TRAIL (H cycles): SCK low, CS still low. CS then rises.
- GAP (H cycles): both CS high.
- Receive path (data frame only; the slave presents bit k after SCK falling edge k):
- Sample `spi_sdi` in the last cycle of each SCK high phase for bits 2..data_width (capturing bits 1..data_width-1).
- Sample bit data_width in the last cycle of DATA_TRAIL.
- Bits shift into an internal register MSB first.
- DONE (1 cycle): copy the receive register to `rxd_data`, `done`=1, `busy`=0.
- `spi_sdi` during the command frame is ignored.
- `rxd_data` holds its value until the next DONE.

## Timing
- Start accepted on clock edge 0. From cycle 1, `busy`=1 and CS is low.
- Defaults (H=4, cmd 8, data 16):
- `spi_cs_cmd` low cycles 1–72 (4 + 64 + 4).
- GAP cycles 73–76.
- `spi_cs_data` low cycles 77–212 (4 + 128 + 4).
- `done` in cycle 213.
- General latency: H·(2·cmd_width + 2·data_width + 5) + 1 cycles from acceptance to `done`.
- Back-to-back: `start` high in the `done` cycle is not accepted (state is DONE). The earliest accept is the following cycle.
- Reset mid-transaction (asynchronous, immediate):
- CS deasserts and SCK returns low.
- `busy` and `done` clear; `rxd_data` clears to 0.
- No partial `done` is produced.
- Outputs `spi_sck`, `spi_sdo`, `spi_cs_*` are registered, with no combinational path from inputs.

## Configuration
- `SPI_MASTER_CMD_PHASE_EN`:
- Defined: full sequence as above.
- Undefined: CMD_LEAD, CMD_SHIFT, CMD_TRAIL and GAP are removed; `spi_cs_cmd` is held at 1 and `cmd_in` is unused.
- Undefined timing: `spi_cs_data` is low in cycles 1–136 (defaults), and `done` occurs in cycle 137. Latency is H·(2·data_width + 2) + 1.

## Test plan
- Reset check: after reset release, all outputs hold their reset values. Pulse `start` with cmd 0xA5, data 0x1234 → slave `dcmd`=0xA5 with `cmd_done` pulse, slave `rxd_data`=0x1234 with `data_done` pulse, master `done` in cycle 213.
- Readback: slave `txd_data`=0xBEEF, master sends 0x0000 → master `rxd_data`=0xBEEF when `done`=1.
- Ignored start: `start` held high for 300 cycles → exactly two `done` pulses. The second transaction is accepted the cycle after the first `done`.
- Async reset: assert `rst`=0 at cycle 100 → same-cycle CS high and SCK low, `busy`=0, no `done`. A new transaction afterwards completes normally.
- Edge patterns: data 0x8001, then 0x7FFE, with slave echo 0x0001 → LSB captured correctly in DATA_TRAIL and `rxd_data`=0x0001.
- Macro off: without `SPI_MASTER_CMD_PHASE_EN`, `spi_cs_cmd` stays 1 throughout and `done` occurs in cycle 137.
